// File: rtl/alu_op_sequencer_if.sv
// Instruction, ALU, result and debug signals between the sequencer and its
// instruction source / ALU. The sequencer takes the slave side.
interface alu_op_sequencer_if #(
    parameter int DATA_W = 4,
    parameter int AW     = 2
);
    logic [9:0]        instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_result;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic [AW-1:0]     res_rd;
    logic              res_zero;
    logic [AW-1:0]     dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport slave (
        input  instr, instr_valid, alu_result, dbg_addr,
        output instr_ready, alu_a, alu_b, alu_ctrl,
               res_valid, res_data, res_rd, res_zero, dbg_data
    );

    modport master (
        output instr, instr_valid, alu_result, dbg_addr,
        input  instr_ready, alu_a, alu_b, alu_ctrl,
               res_valid, res_data, res_rd, res_zero, dbg_data
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle issue controller for the 4-bit combinational ALU: accepts
// instruction words, reads the register file, issues to the ALU, writes back.
module alu_op_sequencer #(
    parameter int DATA_W = 4,
    parameter int NREGS  = 4
) (
    input logic clk,
    input logic rst_n,
    alu_op_sequencer_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WB    = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] rf_q [NREGS];
    logic [DATA_W-1:0] rf_d [NREGS];
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [2:0]        alu_ctrl_q, alu_ctrl_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [DATA_W-1:0] pend_q, pend_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [AW-1:0]     res_rd_q, res_rd_d;
    logic              res_zero_q, res_zero_d;

    always_comb begin
        state_d     = state_q;
        rf_d        = rf_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_ctrl_d  = alu_ctrl_q;
        rd_d        = rd_q;
        pend_d      = pend_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_rd_d    = res_rd_q;
        res_zero_d  = res_zero_q;
        case (state_q)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    rd_d = bus.instr[5:4];
                    if (bus.instr[9]) begin
                        pend_d  = bus.instr[DATA_W-1:0];
                        state_d = S_WB;
                    end else begin
                        alu_a_d    = rf_q[bus.instr[3:2]];
                        alu_b_d    = rf_q[bus.instr[1:0]];
                        alu_ctrl_d = bus.instr[8:6];
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                pend_d  = bus.alu_result;
                state_d = S_WB;
            end
            S_WB: begin
                // Write lands before the next acceptance, so dependent ops see it.
                rf_d[rd_q]  = pend_q;
                res_data_d  = pend_q;
                res_rd_d    = rd_q;
                res_zero_d  = (pend_q == '0);
                res_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= '0;
            rd_q        <= '0;
            pend_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
            res_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rf_q        <= rf_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_ctrl_q  <= alu_ctrl_d;
            rd_q        <= rd_d;
            pend_q      <= pend_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_rd_q    <= res_rd_d;
            res_zero_q  <= res_zero_d;
        end
    end

    // Ready decodes registered state only, never instr_valid.
    assign bus.instr_ready = (state_q == S_IDLE);
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_ctrl    = alu_ctrl_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_rd      = res_rd_q;
    assign bus.res_zero    = res_zero_q;
    assign bus.dbg_data    = rf_q[bus.dbg_addr];
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed and random instructions
// compared against a register-file-level reference model.
module tb_alu_op_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    logic [3:0] ref_rf [4];

    alu_op_sequencer_if #(.DATA_W(4), .AW(2)) bus ();

    alu_op_sequencer #(.DATA_W(4), .NREGS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'd0: return 4'((int'(a) + int'(b)) % 16);
            3'd1: return 4'((int'(a) - int'(b) + 16) % 16);
            3'd2: return a ^ b;
            3'd3: return a | b;
            3'd4: return a & b;
            3'd5: return ~(a | b);
            3'd6: return ~(a & b);
            default: return ~(a ^ b);
        endcase
    endfunction

    assign bus.alu_result = alu_ref(bus.alu_ctrl, bus.alu_a, bus.alu_b);

    function automatic logic [9:0] mk(input bit mode, input logic [2:0] op, input logic [1:0] rd,
                                      input logic [1:0] s1, input logic [1:0] s2);
        return {mode, op, rd, s1, s2};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dbg(input string tag, input logic [1:0] a, input logic [3:0] exp);
        bus.dbg_addr = a;
        #1;
        chk(tag, 32'(bus.dbg_data), 32'(exp));
    endtask

    task automatic do_instr(input logic [9:0] ins);
        logic [3:0] exp;
        int t;
        @(negedge clk);
        bus.instr = ins;
        bus.instr_valid = 1'b1;
        t = 0;
        while (!bus.instr_ready && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (!bus.instr_ready) chk("ready_timeout", 0, 1);
        exp = ins[9] ? ins[3:0] : alu_ref(ins[8:6], ref_rf[ins[3:2]], ref_rf[ins[1:0]]);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        chk("busy_ready", 32'(bus.instr_ready), 0);
        chk("early_valid", 32'(bus.res_valid), 0);
        if (!ins[9]) begin
            chk("alu_a", 32'(bus.alu_a), 32'(ref_rf[ins[3:2]]));
            chk("alu_b", 32'(bus.alu_b), 32'(ref_rf[ins[1:0]]));
            chk("alu_ctrl", 32'(bus.alu_ctrl), 32'(ins[8:6]));
            @(negedge clk);
            chk("wb_valid_early", 32'(bus.res_valid), 0);
        end
        @(negedge clk);
        chk("res_valid", 32'(bus.res_valid), 1);
        chk("res_data", 32'(bus.res_data), 32'(exp));
        chk("res_rd", 32'(bus.res_rd), 32'(ins[5:4]));
        chk("res_zero", 32'(bus.res_zero), 32'(exp == 4'd0));
        ref_rf[ins[5:4]] = exp;
        chk_dbg("dbg_wb", ins[5:4], exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, nres, lo;
        bit drop;
        logic [3:0] e;
        logic [9:0] ins;
        bus.instr = '0;
        bus.instr_valid = 1'b0;
        bus.dbg_addr = '0;
        for (int i = 0; i < 4; i++) ref_rf[i] = 4'd0;

        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(bus.instr_ready), 1);
        chk("rst_valid", 32'(bus.res_valid), 0);
        chk("rst_ctrl", 32'(bus.alu_ctrl), 0);
        for (int i = 0; i < 4; i++) chk_dbg("rst_rf", 2'(i), 4'd0);

        // Directed sequence
        do_instr(10'b10_0101_0101);
        do_instr(mk(1, 3'd0, 2'd2, 2'b00, 2'b11));
        chk_dbg("r1_is_5", 2'd1, 4'd5);
        chk_dbg("r2_is_3", 2'd2, 4'd3);
        do_instr(mk(0, 3'd0, 2'd3, 2'd1, 2'd2));
        chk("add_8", 32'(bus.res_data), 8);
        do_instr(mk(0, 3'd1, 2'd0, 2'd2, 2'd1));
        chk("sub_wrap", 32'(bus.res_data), 32'hE);
        do_instr(mk(0, 3'd2, 2'd0, 2'd1, 2'd1));
        chk("xor_zero", 32'(bus.res_zero), 1);

        // Back-to-back dependent ADDs with instr_valid held
        do_instr(mk(1, 3'd0, 2'd1, 2'b00, 2'b01));
        @(negedge clk);
        bus.instr = mk(0, 3'd0, 2'd1, 2'd1, 2'd1);
        bus.instr_valid = 1'b1;
        acc = 0; nres = 0; lo = 0; drop = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.res_valid) begin
                e = alu_ref(3'd0, ref_rf[1], ref_rf[1]);
                ref_rf[1] = e;
                nres++;
                chk("b2b_data", 32'(bus.res_data), 32'(e));
                chk("b2b_rd", 32'(bus.res_rd), 1);
            end
            if (lo > 0) begin
                chk("b2b_ready_low", 32'(bus.instr_ready), 0);
                lo--;
            end else if (bus.instr_valid && bus.instr_ready) begin
                acc++;
                lo = 2;
                if (acc == 4) drop = 1;
            end
            @(negedge clk);
            if (drop) bus.instr_valid = 1'b0;
        end
        chk("b2b_accepts", 32'(acc), 4);
        chk("b2b_results", 32'(nres), 4);
        chk_dbg("b2b_r1_wrap", 2'd1, 4'd0);

        // Random instructions
        for (int k = 0; k < 30; k++) begin
            ins = mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            do_instr(ins);
        end
        for (int i = 0; i < 4; i++) chk_dbg("rand_rf", 2'(i), ref_rf[i]);

        // Reset during ISSUE drops the in-flight op and clears the rf
        do_instr(mk(1, 3'd0, 2'd3, 2'b01, 2'b11));
        @(negedge clk);
        bus.instr = mk(0, 3'd0, 2'd3, 2'd3, 2'd3);
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        chk("mid_in_issue", 32'(bus.instr_ready), 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.instr_ready), 1);
        chk("mid_rst_valid", 32'(bus.res_valid), 0);
        for (int i = 0; i < 4; i++) ref_rf[i] = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("mid_no_wb", 32'(bus.res_valid), 0);
        end
        chk("mid_ready", 32'(bus.instr_ready), 1);
        for (int i = 0; i < 4; i++) chk_dbg("mid_rf_clear", 2'(i), ref_rf[i]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
